and_result_fifo: RTL and testbench
==================================

AND_RESULT_FIFO -- requirements
Module: and_result_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data width of each buffered result.
REQ-002 Parameter DEPTH, default 4: number of entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  result byte Y from the clocked AND stage.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  FIFO accepts a push this cycle.
REQ-008 out_data  output  WIDTH  head-of-queue entry (first-word-fall-through).
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 count  output  clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-012 overflow  output  1  sticky flag: a push was attempted while full.

Function
REQ-013 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-014 in_ready SHALL equal (count != DEPTH), combinational from registered count only.
REQ-015 out_valid SHALL equal (count != 0); out_data SHALL be the oldest entry, combinationally read from storage.
REQ-016 Entry pushed at edge N SHALL be visible on out_data/out_valid after edge N (one-cycle latency to head).
REQ-017 Push only: write at wr_ptr, wr_ptr+1, count+1.
REQ-018 Pop only: rd_ptr+1, count-1; popped storage is not cleared.
REQ-019 Simultaneous push and pop with 0<count<DEPTH: both pointers advance, count unchanged.
REQ-020 Simultaneous push and pop when full: pop succeeds, push SHALL be refused (in_ready=0), count becomes DEPTH-1, overflow set.
REQ-021 Push attempt when empty with pop asserted: push succeeds, no pop (out_valid=0), count becomes 1.
REQ-022 Pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH with no special-case logic.
REQ-023 in_valid && !in_ready SHALL set overflow; overflow SHALL clear only on reset; dropped data SHALL NOT alter storage.
REQ-024 Data values SHALL be passed unmodified, all WIDTH bits including 8'h00 and 8'hFF.

Reset
REQ-025 With reset high at an edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0.
REQ-026 Outputs after reset: out_valid=0, in_ready=1, count=0, overflow=0; out_data is don't-care.
REQ-027 Reset asserted mid-operation SHALL discard all entries and take priority over simultaneous push/pop.
REQ-028 Storage array SHALL NOT require reset.

Structure
REQ-029 Package and_pkg SHALL hold WIDTH/DEPTH defaults and the derived pointer/count widths.
REQ-030 Storage SHALL be sub-module and_fifo_mem (1 write port, 1 async read port); pointer, count and flag logic in the parent.
REQ-031 The block SHALL sit directly downstream of the clocked AND stage, its in_data driven by that stage's Y output.

Verification
REQ-032 Reset then idle -> out_valid=0, in_ready=1, count=0, overflow=0.
REQ-033 Push 8'hA5, 8'h0F, 8'hFF, 8'h00 with out_ready=0 -> count=4, in_ready=0; then pop 4 -> out_data A5,0F,FF,00 in order, count=0.
REQ-034 Fill with 4 entries, hold in_valid with 8'h33 one cycle -> overflow=1, count=4, popped sequence excludes 33; overflow stays 1 until reset.
REQ-035 count=2, push 8'h11 and pop same cycle for 10 cycles -> count stays 2, output order matches input order across pointer wrap.
REQ-036 Full FIFO, push 8'h77 and pop same cycle -> count=3, overflow=1, 77 never appears at output.
REQ-037 count=3, assert reset with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, overflow=0.

Source files
------------

// File: rtl/and_pkg.sv
// Shared sizing for the AND-stage result FIFO: default geometry and derived widths.
package and_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_PTR_W = $clog2(DEF_DEPTH);
    localparam int unsigned DEF_CNT_W = DEF_PTR_W + 1;

endpackage

// File: rtl/and_fifo_mem.sv
// Result storage: one synchronous write port, one asynchronous read port, no reset.
module and_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/and_result_fifo.sv
// First-word-fall-through FIFO buffering results from the clocked AND stage.
module and_result_fifo
    import and_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Handshake decode uses registered count only, so a full FIFO refuses a push even while popping.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != CNT_W'(0));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    and_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_and_result_fifo.sv
// Scoreboard bench for and_result_fifo: directed pushes queue expected data, a monitor checks pops.
module tb_and_result_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       count;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               mcount = 0;
    logic             m_ovf  = 1'b0;

    and_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sampled mid-cycle, pops the scoreboard whenever the DUT hands off a word.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (out_valid !== (mcount != 0)) begin
                failures++;
                $display("FAIL out_valid: got %0b want %0b", out_valid, (mcount != 0));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected: got %02h want <none>", out_data);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        failures++;
                        $display("FAIL pop_data: got %02h want %02h", out_data, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, int'(count), mcount);
        chk({tag, "_in_ready"}, int'(in_ready), int'(mcount != DEPTH));
        chk({tag, "_overflow"}, int'(overflow), int'(m_ovf));
    endtask

    // One clock of stimulus; the bench model decides acceptance independently of the DUT.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r);
        logic acc, pp;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        acc = v && (mcount != DEPTH);
        pp  = r && (mcount != 0);
        if (acc) exp_q.push_back(d);
        @(posedge clk);
        mcount = mcount + int'(acc) - int'(pp);
        if (v && !acc) m_ovf = 1'b1;
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset(input logic v, input logic r);
        reset     = 1'b1;
        in_valid  = v;
        in_data   = 8'hEE;
        out_ready = r;
        @(posedge clk);
        mcount = 0;
        m_ovf  = 1'b0;
        exp_q.delete();
        #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] vec [4];
        vec[0] = 8'hA5; vec[1] = 8'h0F; vec[2] = 8'hFF; vec[3] = 8'h00;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk_state("reset_idle");
        chk("reset_out_valid", int'(out_valid), 0);

        // Fill with boundary data values, then drain in order.
        for (int i = 0; i < 4; i++) cyc(1'b1, vec[i], 1'b0);
        chk_state("full");
        chk("full_count_const", int'(count), 4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
        chk_state("drained");

        // Overflow: push while full is dropped and the flag sticks.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h01 + i), 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        chk_state("ovf");
        chk("ovf_flag_const", int'(overflow), 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
        chk_state("ovf_drained");
        chk("ovf_sticky", int'(overflow), 1);

        // Steady-state push+pop across pointer wrap.
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 8'hC1, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'(8'h11 + i), 1'b1);
            chk("stream_count", int'(count), 2);
        end
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        chk_state("stream_drained");

        // Full with simultaneous push+pop: pop wins, push refused.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        cyc(1'b1, 8'h77, 1'b1);
        chk_state("full_pushpop");
        chk("full_pushpop_count", int'(count), 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
        chk_state("full_pushpop_drained");

        // Empty with simultaneous push+pop: only the push lands.
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 8'h5A, 1'b1);
        chk_state("empty_pushpop");
        cyc(1'b0, 8'h00, 1'b1);

        // Reset wins over a concurrent push and pop.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0);
        chk_state("pre_reset");
        do_reset(1'b1, 1'b1);
        chk_state("mid_reset");
        chk("mid_reset_out_valid", int'(out_valid), 0);
        cyc(1'b0, 8'h00, 1'b0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
